// File: rtl/spi_pkg.sv
// Shared SPI peripheral types and bit-order helpers.
// Define SPI_PERIPHERAL_LSB_FIRST_EN for LSB-first shifting in both directions.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_FILL = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Bit-order selection lives here so the top-level datapath is order-agnostic.
  function automatic logic tx_out_bit(input logic [SPI_BYTE_W-1:0] s);
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    return s[0];
`else
    return s[SPI_BYTE_W-1];
`endif
  endfunction

  function automatic logic [SPI_BYTE_W-1:0] tx_advance(input logic [SPI_BYTE_W-1:0] s);
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    return {1'b0, s[SPI_BYTE_W-1:1]};
`else
    return {s[SPI_BYTE_W-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [SPI_BYTE_W-1:0] rx_insert(input logic [SPI_BYTE_W-1:0] s,
                                                      input logic b);
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    return {b, s[SPI_BYTE_W-1:1]};
`else
    return {s[SPI_BYTE_W-2:0], b};
`endif
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a selectable reset value.
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral (CPOL=0, CPHA=1) with a one-byte TX holding buffer.
// Build option SPI_PERIPHERAL_LSB_FIRST_EN selects LSB-first bit order.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid
);

  logic sclk_s, cs_n_s, mosi_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(spi_sclk), .q_o(sclk_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n), .q_o(cs_n_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(spi_mosi), .q_o(mosi_s)
  );

  logic sclk_prev_q, cs_n_prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;

  spi_state_e            state_q;
  logic                  miso_q;
  logic [SPI_BYTE_W-1:0] tx_shift_q, rx_shift_q, rx_data_q, tx_buf_q, rx_next;
  logic [2:0]            bit_cnt_q;
  logic                  rx_valid_q, tx_ready_q;
  logic                  byte_done, tx_reload;
  logic [SPI_BYTE_W-1:0] tx_reload_val;

  // A cs_n rise wins over a coincident sclk fall so an aborted byte never completes.
  assign byte_done     = (state_q == SHIFT) & ~cs_rise & sclk_fall & (bit_cnt_q == 3'd7);
  assign tx_reload     = ((state_q == IDLE) & cs_fall) | byte_done;
  assign tx_reload_val = tx_ready_q ? SPI_IDLE_FILL : tx_buf_q;
  assign rx_next       = rx_insert(rx_shift_q, mosi_s);

  // Holding buffer: a reload drains it; otherwise a load is accepted only when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_buf_q   <= SPI_IDLE_FILL;
      tx_ready_q <= 1'b1;
    end else if (tx_reload && !tx_ready_q) begin
      tx_ready_q <= 1'b1;
    end else if (tx_load && tx_ready_q) begin
      tx_buf_q   <= tx_data;
      tx_ready_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      miso_q     <= 1'b0;
      tx_shift_q <= SPI_IDLE_FILL;
      rx_shift_q <= '0;
      bit_cnt_q  <= 3'd0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q    <= 1'b0;
          bit_cnt_q <= 3'd0;
          if (cs_fall) begin
            state_q    <= SHIFT;
            tx_shift_q <= tx_reload_val;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q   <= IDLE;
            miso_q    <= 1'b0;
            bit_cnt_q <= 3'd0;
          end else begin
            if (sclk_rise) begin
              miso_q     <= tx_out_bit(tx_shift_q);
              tx_shift_q <= tx_advance(tx_shift_q);
            end
            if (sclk_fall) begin
              rx_shift_q <= rx_next;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data_q  <= rx_next;
                rx_valid_q <= 1'b1;
                tx_shift_q <= tx_reload_val;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed testbench for spi_peripheral acting as the SPI initiator.
module tb_spi_peripheral;

`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  int errors = 0;
  int checks = 0;

  int         pulse_cnt = 0;
  int         width_err = 0;
  logic       vld_prev = 1'b0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;

  spi_peripheral #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      pulse_cnt <= pulse_cnt + 1;
      rx_prev   <= rx_last;
      rx_last   <= rx_data;
      if (vld_prev) width_err <= width_err + 1;
    end
    vld_prev <= rx_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    @(negedge clk);
    spi_cs_n = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = LSB ? i : 7 - i;
      @(negedge clk);
      spi_sclk = 1'b1;
      spi_mosi = mo[idx];
      wait_clks(HALF);
      mi[idx]  = spi_miso;
      spi_sclk = 1'b0;
      wait_clks(HALF);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_single();
    logic [7:0] mi;
    int base;
    base = pulse_cnt;
    load(8'hA5);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_tx_ready_drop got=%b exp=0", tx_ready); end
    cs_low();
    xfer(8'h3C, 8, mi);
    cs_high();
    checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL single_miso got=%h exp=a5", mi); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data got=%h exp=3c", rx_data); end
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulse_cnt - base); end
    checks++; if (width_err !== 0) begin errors++; $display("FAIL single_pulse_width got=%0d exp=0", width_err); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_tx_ready_after got=%b exp=1", tx_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    int base, n;
    base = pulse_cnt;
    load(8'h11);
    cs_low();
    n = 0;
    while (tx_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_tx_ready_rise got=%b exp=1", tx_ready); end
    load(8'h22);
    xfer(8'hF0, 8, mi1);
    xfer(8'h0F, 8, mi2);
    cs_high();
    checks++; if (mi1 !== 8'h11) begin errors++; $display("FAIL b2b_miso1 got=%h exp=11", mi1); end
    checks++; if (mi2 !== 8'h22) begin errors++; $display("FAIL b2b_miso2 got=%h exp=22", mi2); end
    checks++; if (pulse_cnt - base !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulse_cnt - base); end
    checks++; if (rx_prev !== 8'hF0) begin errors++; $display("FAIL b2b_rx1 got=%h exp=f0", rx_prev); end
    checks++; if (rx_last !== 8'h0F) begin errors++; $display("FAIL b2b_rx2 got=%h exp=0f", rx_last); end
    checks++; if (width_err !== 0) begin errors++; $display("FAIL b2b_pulse_width got=%0d exp=0", width_err); end
  endtask

  task automatic test_empty();
    logic [7:0] mi;
    cs_low();
    xfer(8'hFF, 8, mi);
    cs_high();
    checks++; if (mi !== 8'h00) begin errors++; $display("FAIL empty_miso got=%h exp=00", mi); end
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL empty_rx_data got=%h exp=ff", rx_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL empty_tx_ready got=%b exp=1", tx_ready); end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int base;
    base = pulse_cnt;
    cs_low();
    xfer(8'hC3, 5, mi);
    cs_high();
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL abort_partial_pulses got=%0d exp=0", pulse_cnt - base); end
    cs_low();
    xfer(8'h81, 8, mi);
    cs_high();
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL abort_next_rx got=%h exp=81", rx_data); end
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL abort_next_pulses got=%0d exp=1", pulse_cnt - base); end
  endtask

  task automatic test_overload_reset();
    logic [7:0] mi;
    int base;
    load(8'h55);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL ovl_tx_ready got=%b exp=0", tx_ready); end
    load(8'hAA);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL ovl_tx_ready_hold got=%b exp=0", tx_ready); end
    cs_low();
    xfer(8'h5A, 8, mi);
    cs_high();
    checks++; if (mi !== 8'h55) begin errors++; $display("FAIL ovl_miso got=%h exp=55", mi); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL ovl_rx_data got=%h exp=5a", rx_data); end
    load(8'h77);
    cs_low();
    xfer(8'hE7, 4, mi);
    base = pulse_cnt;
    @(negedge clk);
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    wait_clks(2);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rst_mid_miso got=%b exp=0", spi_miso); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_ready got=%b exp=1", tx_ready); end
    rst_n = 1'b1;
    wait_clks(2 * HALF);
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulse_cnt - base); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_after_rx_data got=%h exp=00", rx_data); end
  endtask

`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
  task automatic test_lsb_first();
    logic [7:0] mi;
    load(8'h01);
    cs_low();
    xfer(8'h80, 8, mi);
    cs_high();
    checks++; if (mi[0] !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got=%b exp=1", mi[0]); end
    checks++; if (mi !== 8'h01) begin errors++; $display("FAIL lsb_miso got=%h exp=01", mi); end
    checks++; if (rx_data !== 8'h80) begin errors++; $display("FAIL lsb_rx_data got=%h exp=80", rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_abort();
    test_overload_reset();
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each SPI input (legal range 2..4).
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  reset: synchronous, active-low.
REQ-004 spi_sclk  input  1  SPI clock from the initiator; idles low.
REQ-005 spi_cs_n  input  1  chip select, active-low.
REQ-006 spi_mosi  input  1  serial data from the initiator.
REQ-007 spi_miso  output  1  serial data to the initiator.
REQ-008 tx_data  input  8  next byte to return to the initiator.
REQ-009 tx_load  input  1  strobe: write tx_data into the TX holding buffer.
REQ-010 tx_ready  output  1  high when the TX holding buffer is empty.
REQ-011 rx_data  output  8  last complete received byte.
REQ-012 rx_valid  output  1  one-cycle pulse when rx_data has been updated.

Function
REQ-013 spi_sclk, spi_cs_n and spi_mosi SHALL each pass through SYNC_STAGES flops; the synchronized spi_sclk SHALL be edge-detected against its previous value.
REQ-014 The SPI mode SHALL be CPOL=0, CPHA=1:
- spi_miso changes on each synchronized sclk rising edge.
- spi_mosi is sampled on each synchronized sclk falling edge.
REQ-015 Each spi_sclk half-period SHALL be at least SYNC_STAGES+2 clk cycles; operation outside this limit is undefined.
REQ-016 FSM states: IDLE (cs_n high) and SHIFT (cs_n low).
- IDLE->SHIFT on synchronized cs_n falling.
- SHIFT->IDLE on synchronized cs_n rising.
REQ-017 On entry to SHIFT, and after each completed byte:
- The TX shift register SHALL load the holding buffer if it is full, else 8'h00.
- A full buffer SHALL be marked empty by this load (tx_ready=1 next cycle).
REQ-018 On each sclk rise in SHIFT: spi_miso <= tx_shift[7], then tx_shift shifts left with zero fill.
REQ-019 On each sclk fall in SHIFT: rx_shift <= {rx_shift[6:0], mosi}, and the 3-bit bit counter increments, wrapping 7->0.
REQ-020 On the 8th sclk fall of a byte:
- rx_data SHALL take the assembled byte.
- rx_valid SHALL pulse for exactly 1 cycle, 1 cycle after that fall.
REQ-021 tx_load with tx_ready=1 SHALL capture tx_data, and tx_ready SHALL drop the next cycle.
REQ-022 tx_load with tx_ready=0 SHALL be ignored; the buffer is not overwritten.
REQ-023 tx_load in the same cycle as a load from an empty buffer: the current byte SHALL send 8'h00, and the new data SHALL stay buffered for the next byte.
REQ-024 cs_n rising mid-byte SHALL:
- discard the partial byte, with no rx_valid;
- clear the bit counter;
- keep the holding buffer contents.
REQ-025 In IDLE, spi_miso SHALL hold 0, and sclk edges SHALL be ignored.
REQ-026 Back-to-back bytes within one cs_n-low period SHALL be supported with no gap cycles required.

Reset
REQ-027 While rst_n=0 at a clk edge, all state SHALL reset:
- FSM=IDLE, spi_miso=0, rx_data=8'h00, rx_valid=0, tx_ready=1;
- shift registers, bit counter and synchronizers cleared (sclk and mosi synchronizers to 0, cs_n synchronizer to 1).
REQ-028 Reset mid-transfer SHALL abort the transfer with no rx_valid; a transfer restarts only on a fresh cs_n falling edge.

Configuration
REQ-029 Macro SPI_PERIPHERAL_LSB_FIRST_EN:
- When defined, both directions SHALL be LSB-first (tx shifts right, emitting bit 0; rx fills from bit 7 downward).
- When undefined, both directions SHALL be MSB-first as in REQ-018/019.
- The interface SHALL be identical in both builds.

Structure
REQ-030 Shared package spi_pkg SHALL hold:
- SPI_BYTE_W=8;
- SPI_IDLE_FILL=8'h00;
- the FSM state typedef (IDLE, SHIFT).
REQ-031 One sub-module, spi_sync, SHALL implement the SYNC_STAGES-deep flop chain with a reset value parameter; it is instantiated three times.

Verification
REQ-032 Single byte: load tx 8'hA5, cs_n low, initiator sends 8'h3C (sclk half-period 8 clk) -> miso shows A5 MSB-first; rx_data=8'h3C with one 1-cycle rx_valid pulse.
REQ-033 Back-to-back: buffer 8'h11, reload 8'h22 when tx_ready rises, initiator sends 8'hF0, 8'h0F in one cs_n window -> miso 11 then 22; two rx_valid pulses carrying F0 and 0F.
REQ-034 Empty buffer: no tx_load, transfer 8'hFF -> miso all zeros; rx_data=8'hFF; tx_ready stays 1.
REQ-035 Abort: cs_n high after 5 sclk falls, then a full byte 8'h81 -> no rx_valid for the partial byte; next rx_data=8'h81.
REQ-036 Overload and reset: tx_load 8'h55 then 8'hAA with tx_ready=0 -> 8'h55 sent; rst_n low mid-byte -> outputs at reset values and no rx_valid.
REQ-037 LSB-first build (macro defined): tx 8'h01, initiator sends 8'h80 LSB-first -> first miso bit 1; rx_data=8'h80.
